// File: rtl/damage_calc_arbiter.sv
// Round-robin arbiter sharing one damage calculator between NUM_REQ unit lanes.
// Optional WAIT-state watchdog enabled by defining DAMAGE_ARB_TIMEOUT_EN.
module damage_calc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      round_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_atk,
  input  logic [NUM_REQ*DATA_W-1:0] req_def,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_dmg,
  output logic                      calc_start,
  output logic [DATA_W-1:0]         calc_atk,
  output logic [DATA_W-1:0]         calc_def,
  input  logic                      calc_done,
  input  logic [DATA_W-1:0]         calc_dmg,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               timed_out;

  // Round-robin search: the lane after the last winner has highest priority.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end else begin
        found = found;
      end
    end
  end

`ifdef DAMAGE_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // A done arriving on the final WAIT cycle takes precedence over the timeout.
  assign timed_out = (state == WAIT) && !calc_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // WAIT cycle counter, held at zero outside WAIT so it restarts on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (round_en && found) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (calc_done || timed_out) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, pointer and operand latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      resp_valid  <= '0;
      resp_dmg    <= '0;
      calc_start  <= 1'b0;
      calc_atk    <= '0;
      calc_def    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      calc_start  <= (state_next == START);
      busy        <= (state_next != IDLE);
      timeout_err <= timed_out;
      case (state)
        IDLE: begin
          if (state_next == START) begin
            grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            ptr      <= win;
            calc_atk <= req_atk[int'(win)*DATA_W +: DATA_W];
            calc_def <= req_def[int'(win)*DATA_W +: DATA_W];
          end
        end
        WAIT: begin
          if (state_next == RESP) begin
            resp_valid <= grant;
            resp_dmg   <= calc_done ? calc_dmg : {DATA_W{1'b0}};
          end
        end
        RESP: begin
          grant      <= '0;
          resp_valid <= '0;
        end
        default: begin
          grant      <= grant;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_damage_calc_arbiter.sv
// Self-checking bench for damage_calc_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin model.
module tb_damage_calc_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
`ifdef DAMAGE_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          round_en;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_atk;
  logic [N*DW-1:0] req_def;
  logic [N-1:0]  grant;
  logic [N-1:0]  resp_valid;
  logic [DW-1:0] resp_dmg;
  logic          calc_start;
  logic [DW-1:0] calc_atk;
  logic [DW-1:0] calc_def;
  logic          calc_done;
  logic [DW-1:0] calc_dmg;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int last   = N - 1;

  damage_calc_arbiter #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .round_en(round_en), .req(req),
    .req_atk(req_atk), .req_def(req_def), .grant(grant), .resp_valid(resp_valid),
    .resp_dmg(resp_dmg), .calc_start(calc_start), .calc_atk(calc_atk),
    .calc_def(calc_def), .calc_done(calc_done), .calc_dmg(calc_dmg),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requesting lane after the previous winner.
  function automatic int pick(input logic [N-1:0] r, input int prev);
    for (int k = 1; k <= N; k++) begin
      if (r[(prev + k) % N]) return (prev + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [N*DW-1:0] v, input int l);
    return v[l*DW +: DW];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'h0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, ".calc_start"}, 32'(calc_start), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  // Drives one transaction from the IDLE sampling edge to the return to IDLE.
  task automatic run_txn(input int lane, input logic [DW-1:0] atk, input logic [DW-1:0] dfn,
                         input int dly, input logic [DW-1:0] dmg, input logic en_after,
                         input logic [N-1:0] req_after);
    logic [N-1:0] g;
    g = 4'b0001 << lane;
    tick();
    check("start.grant", 32'(grant), 32'(g));
    check("start.calc_start", 32'(calc_start), 32'h1);
    check("start.calc_atk", 32'(calc_atk), 32'(atk));
    check("start.calc_def", 32'(calc_def), 32'(dfn));
    check("start.busy", 32'(busy), 32'h1);
    round_en  = en_after;
    req       = req_after;
    req_atk   = {$urandom, $urandom};
    req_def   = {$urandom, $urandom};
    calc_done = 1'($urandom_range(0, 1));
    tick();
    check("wait.calc_start", 32'(calc_start), 32'h0);
    check("wait.calc_atk", 32'(calc_atk), 32'(atk));
    calc_done = 1'b0;
    for (int i = 1; i < dly; i++) begin
      tick();
      check("wait.resp_valid", 32'(resp_valid), 32'h0);
      check("wait.calc_def", 32'(calc_def), 32'(dfn));
    end
    calc_done = 1'b1;
    calc_dmg  = dmg;
    tick();
    check("resp.resp_valid", 32'(resp_valid), 32'(g));
    check("resp.resp_dmg", 32'(resp_dmg), 32'(dmg));
    check("resp.grant", 32'(grant), 32'(g));
    check("resp.timeout_err", 32'(timeout_err), 32'h0);
    calc_done = 1'($urandom_range(0, 1));
    calc_dmg  = 16'($urandom);
    tick();
    check_all_zero("post");
  endtask

  initial begin
    logic [N-1:0] r;
    int lane;
    reset = 1'b1; round_en = 1'b1; req = 4'b0000;
    req_atk = '0; req_def = '0; calc_done = 1'b0; calc_dmg = 16'h0000;
    tick(); tick();
    check_all_zero("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      calc_done = 1'($urandom_range(0, 1));
      tick();
      check("idle.grant", 32'(grant), 32'h0);
    end
    check_all_zero("idle");

    // Lane 2 alone, calculator answers on the 3rd WAIT cycle.
    req = 4'b0100;
    req_atk = {$urandom, $urandom}; req_def = {$urandom, $urandom};
    req_atk[47:32] = 16'h0030; req_def[47:32] = 16'h0010;
    run_txn(2, 16'h0030, 16'h0010, 3, 16'h0020, 1'b1, 4'b0000);
    last = 2;

    // Fairness from reset with all lanes requesting.
    reset = 1'b1; #1; reset = 1'b0; last = N - 1;
    for (int i = 0; i < 5; i++) begin
      req = 4'b1111;
      req_atk = {$urandom, $urandom}; req_def = {$urandom, $urandom};
      lane = pick(req, last);
      run_txn(i % N, lane_of(req_atk, i % N), lane_of(req_def, i % N), 1,
              16'($urandom), 1'b1, 4'b1111);
      last = lane;
    end

    // round_en gating.
    round_en = 1'b0; req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gated.grant", 32'(grant), 32'h0);
    end
    round_en = 1'b1;
    run_txn(0, lane_of(req_atk, 0), lane_of(req_def, 0), 2, 16'h1234, 1'b0, 4'b0011);
    last = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gated_after.grant", 32'(grant), 32'h0);
    end
    round_en = 1'b1;
    run_txn(1, lane_of(req_atk, 1), lane_of(req_def, 1), 1, 16'h5678, 1'b1, 4'b0000);
    last = 1;

    // Reset while waiting on the calculator.
    req = 4'b0100; calc_done = 1'b0;
    tick(); tick();
    check("rst_wait.grant", 32'(grant), 32'h4);
    reset = 1'b1; #1;
    check_all_zero("rst_async");
    check("rst_async.calc_atk", 32'(calc_atk), 32'h0);
    tick();
    check_all_zero("rst_hold");
    req = 4'b1111; reset = 1'b0; last = N - 1;
    run_txn(0, lane_of(req_atk, 0), lane_of(req_def, 0), 2, 16'h00aa, 1'b1, 4'b0000);
    last = 0;

    // Randomized traffic against the round-robin model.
    for (int t = 0; t < 60; t++) begin
      r = 4'($urandom_range(0, 15));
      req = r;
      round_en = ($urandom_range(0, 7) != 0);
      req_atk = {$urandom, $urandom}; req_def = {$urandom, $urandom};
      calc_done = 1'($urandom_range(0, 1));
      lane = pick(r, last);
      if (!round_en || lane < 0) begin
        tick();
        check("rand_idle.grant", 32'(grant), 32'h0);
        check("rand_idle.busy", 32'(busy), 32'h0);
      end else begin
        run_txn(lane, lane_of(req_atk, lane), lane_of(req_def, lane),
                $urandom_range(1, 4), 16'($urandom), 1'b1, 4'($urandom_range(0, 15)));
        last = lane;
      end
    end

    // Calculator never answers.
    round_en = 1'b1; req = 4'b0001; calc_done = 1'b0;
    lane = pick(req, last);
    tick();
    check("hang.grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
`ifdef DAMAGE_ARB_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) begin
      tick();
      check("tmo_wait.resp_valid", 32'(resp_valid), 32'h0);
    end
    tick();
    check("tmo.resp_valid", 32'(resp_valid), 32'h1);
    check("tmo.resp_dmg", 32'(resp_dmg), 32'h0);
    check("tmo.timeout_err", 32'(timeout_err), 32'h1);
    tick();
    check_all_zero("tmo_post");
    last = lane;
    req = 4'b0001;
    lane = pick(req, last);
    run_txn(lane, lane_of(req_atk, lane), lane_of(req_def, lane), TMO, 16'hbeef, 1'b1, 4'b0000);
    last = lane;
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold.busy", 32'(busy), 32'h1);
      check("hold.resp_valid", 32'(resp_valid), 32'h0);
    end
    check("hold.grant", 32'(grant), 32'h1);
    check("hold.timeout_err", 32'(timeout_err), 32'h0);
    calc_done = 1'b1; calc_dmg = 16'h0c0d;
    tick();
    check("hold_end.resp_valid", 32'(resp_valid), 32'h1);
    check("hold_end.resp_dmg", 32'(resp_dmg), 32'h0c0d);
    calc_done = 1'b0;
    tick();
    check_all_zero("hold_post");
    last = lane;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
